// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter: round-robin sharing of one single-port 32-bit on-chip
// memory between two Avalon-style masters. One access is granted per cycle,
// read data is routed back to the issuing port one cycle later, out-of-range
// accesses are filtered with an error pulse, and contended cycles are counted.
module onchip_mem_arbiter #(
  parameter int DEPTH = 5120,
  parameter int AW    = 13,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    m0_address,
  input  logic [3:0]       m0_byteenable,
  input  logic             m0_read,
  input  logic             m0_write,
  input  logic [31:0]      m0_writedata,
  output logic             m0_waitrequest,
  output logic [31:0]      m0_readdata,
  output logic             m0_readdatavalid,
  output logic             m0_err,
  input  logic [AW-1:0]    m1_address,
  input  logic [3:0]       m1_byteenable,
  input  logic             m1_read,
  input  logic             m1_write,
  input  logic [31:0]      m1_writedata,
  output logic             m1_waitrequest,
  output logic [31:0]      m1_readdata,
  output logic             m1_readdatavalid,
  output logic             m1_err,
  output logic [AW-1:0]    mem_address,
  output logic [3:0]       mem_byteenable,
  output logic             mem_chipselect,
  output logic             mem_write,
  output logic [31:0]      mem_writedata,
  input  logic [31:0]      mem_readdata,
  output logic [CNT_W-1:0] contention_count
);

  // DEPTH widened by one bit so DEPTH == 2**AW still compares correctly.
  localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic addr_ok(input logic [AW-1:0] a);
    return {1'b0, a} < DEPTH_L;
  endfunction

  logic             req0, req1;
  logic             gnt0, gnt1, grant;
  logic [AW-1:0]    win_addr;
  logic [3:0]       win_be;
  logic [31:0]      win_wd;
  logic             win_wr, win_rd, in_range;
  logic             ret_ok;

  // last_grant_q = 1 means port 1 won most recently, so port 0 wins a tie.
  logic             last_grant_q, last_grant_d;
  logic             rd_valid_q, rd_valid_d;
  logic             rd_port_q, rd_port_d;
  logic             rd_oor_q, rd_oor_d;
  logic [1:0]       err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Arbitration: lone requester wins, a tie goes to the port that did not win last.
  always_comb begin
    req0 = m0_read | m0_write;
    req1 = m1_read | m1_write;
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (req0 && req1) begin
        gnt0 = last_grant_q;
        gnt1 = ~last_grant_q;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
    grant = gnt0 | gnt1;
  end

  // Memory-side mux of the winning port; everything is zero with no grant.
  always_comb begin
    win_addr = '0;
    win_be   = '0;
    win_wd   = '0;
    win_wr   = 1'b0;
    win_rd   = 1'b0;
    if (gnt0) begin
      win_addr = m0_address;
      win_be   = m0_byteenable;
      win_wd   = m0_writedata;
      win_wr   = m0_write;
      win_rd   = m0_read & ~m0_write;
    end else if (gnt1) begin
      win_addr = m1_address;
      win_be   = m1_byteenable;
      win_wd   = m1_writedata;
      win_wr   = m1_write;
      win_rd   = m1_read & ~m1_write;
    end
    in_range       = addr_ok(win_addr);
    mem_address    = win_addr;
    mem_byteenable = win_be;
    mem_writedata  = win_wd;
    mem_write      = grant & win_wr;
    mem_chipselect = grant & in_range;
  end

  // Next state: grant history, read-return tracking, error pulses, counter.
  always_comb begin
    last_grant_d = grant ? gnt1 : last_grant_q;
    rd_valid_d   = grant & win_rd;
    rd_port_d    = gnt1;
    rd_oor_d     = ~in_range;
    err_d        = {gnt1 & ~in_range, gnt0 & ~in_range};
    cnt_d        = (req0 & req1) ? sat_inc(cnt_q) : cnt_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      rd_valid_q   <= 1'b0;
      rd_port_q    <= 1'b0;
      rd_oor_q     <= 1'b0;
      err_q        <= 2'b00;
      cnt_q        <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      rd_valid_q   <= rd_valid_d;
      rd_port_q    <= rd_port_d;
      rd_oor_q     <= rd_oor_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  // Port-side outputs; reset masks any return or error still in the pipe.
  always_comb begin
    m0_waitrequest   = ~gnt0;
    m1_waitrequest   = ~gnt1;
    ret_ok           = rd_valid_q & ~reset;
    m0_readdatavalid = ret_ok & ~rd_port_q;
    m1_readdatavalid = ret_ok & rd_port_q;
    m0_readdata      = (m0_readdatavalid && !rd_oor_q) ? mem_readdata : '0;
    m1_readdata      = (m1_readdatavalid && !rd_oor_q) ? mem_readdata : '0;
    m0_err           = err_q[0] & ~reset;
    m1_err           = err_q[1] & ~reset;
    contention_count = cnt_q;
  end

endmodule
